fetch_stage: RTL and testbench

Instruction-fetch stage of the three-stage RV32I pipeline. It holds the program counter and issues one word request at a time to instruction memory. It registers each returned word with its PC into the IF/ID register that feeds decode and the immediate generator. It supports decode stall, execute-stage redirect (taken branch, JAL, JALR) with wrong-path squash, and variable-latency memory responses.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One word request per strobe; the response strobe carries the word back.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem request, IF/ID register
// with decode stall, execute redirect / wrong-path squash and variable memory latency.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_2000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_stage_if.master       imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP, HOLD} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] skid_q;

  logic        accept;
  logic        issue;
  logic        load;
  logic [31:0] redir_pc;
  logic [31:0] pc_sel;
  logic [31:0] fetch_addr;
  logic [31:0] load_instr;

  always_comb begin
    accept     = !if_valid || !stall;
    redir_pc   = {redirect_pc[31:2], 2'b00};
    // A redirect always wins the fetch address, whichever state issues.
    pc_sel     = redirect ? redir_pc : pc_q;
    fetch_addr = {pc_sel[31:2], 2'b00};
    issue      = 1'b0;
    load       = 1'b0;
    load_instr = imem.imem_rdata;
    case (state)
      IDLE: issue = redirect || accept;
      BUSY: begin
        if (imem.imem_rvalid) begin
          issue = redirect || accept;
          load  = !redirect && accept;
        end
      end
      HOLD: begin
        issue      = redirect || !stall;
        load       = !redirect && !stall;
        load_instr = skid_q;
      end
      DROP: issue = imem.imem_rvalid;
      default: ;
    endcase
  end

  // Gated by rst_n so no strobe leaks out while held in reset.
  assign imem.imem_req  = issue && rst_n;
  assign imem.imem_addr = imem.imem_req ? fetch_addr : 32'h0;

  // Control: FSM, PC and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= NOP_INSTR;
    end else begin
      if (issue) begin
        state <= BUSY;
        pc_q  <= fetch_addr + 32'd4;
      end else begin
        case (state)
          BUSY: begin
            if (!imem.imem_rvalid && redirect) begin
              pc_q  <= redir_pc;
              state <= DROP;
            end else if (imem.imem_rvalid) begin
              state <= HOLD;
            end
          end
          DROP: if (redirect) pc_q <= redir_pc;
          default: ;
        endcase
      end

      if (redirect) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end else if (load) begin
        if_valid <= 1'b1;
        if_pc    <= addr_q;
        if_instr <= load_instr;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

  // Data: request address and skid word, qualified by control only
  always_ff @(posedge clk) begin
    if (issue) addr_q <= fetch_addr;
    if (state == BUSY && imem.imem_rvalid && !issue) skid_q <= imem.imem_rdata;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected IF/ID words,
// a monitor pops and compares them whenever decode consumes an instruction.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   lat  = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_2000: mem_word = 32'h0050_0093;
      32'h0000_2004: mem_word = 32'h00A0_0113;
      default:       mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Instruction memory: response exactly lat cycles after the request.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] a;
    pend = 1'b0;
    cnt  = 0;
    a    = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (!rst_n) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(a);
          pend = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else if (bus.imem_req) begin
        pend = 1'b1;
        cnt  = lat;
        a    = bus.imem_addr;
      end
    end
  end

  // Monitor: decode consumes when if_valid && !stall and the word is not being squashed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_word: got pc %h instr %h, expected none", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.instr);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
  endtask

  // Leaves the bench at the start of cycle 0, the first cycle with rst_n high.
  task automatic do_reset(input int l);
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    lat         = l;
    exp_q.delete();
    repeat (2) @(posedge clk);
    mid();
    chk_reset_vals();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic end_scn(input string nm);
    stall = 1'b1;
    mid();
    #1;
    chk({nm, "_leftover"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    // L=1 back-to-back stream
    do_reset(1);
    push(32'h2000, 32'h0050_0093);
    push(32'h2004, 32'h00A0_0113);
    push(32'h2008, 32'hA5A5_2008);
    push(32'h200C, 32'hA5A5_200C);
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("s1_req", {31'h0, bus.imem_req}, 32'h1);
      chk("s1_addr", bus.imem_addr, 32'h2000 + 32'(4 * k));
      if (k == 1) chk("s1_valid_c1", {31'h0, if_valid}, 32'h0);
      if (k == 2) chk("s1_valid_c2", {31'h0, if_valid}, 32'h1);
      nxt();
    end
    end_scn("s1");

    // Stall for 3 cycles while a response returns
    do_reset(1);
    push(32'h2000, 32'h0050_0093);
    push(32'h2004, 32'h00A0_0113);
    push(32'h2008, 32'hA5A5_2008);
    nxt();
    nxt();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("s2_stall_req", {31'h0, bus.imem_req}, 32'h0);
      chk("s2_stall_pc", if_pc, 32'h2000);
      chk("s2_stall_instr", if_instr, 32'h0050_0093);
      nxt();
    end
    stall = 1'b0;
    mid();
    chk("s2_rel_req", {31'h0, bus.imem_req}, 32'h1);
    chk("s2_rel_addr", bus.imem_addr, 32'h2008);
    nxt();
    mid();
    chk("s2_skid_pc", if_pc, 32'h2004);
    chk("s2_skid_instr", if_instr, 32'h00A0_0113);
    nxt();
    nxt();
    end_scn("s2");

    // Redirect with an L=3 request to 0x2008 outstanding
    do_reset(3);
    push(32'h2000, 32'h0050_0093);
    push(32'h3000, 32'hA5A5_3000);
    repeat (7) nxt();
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    mid();
    chk("s3_redir_req", {31'h0, bus.imem_req}, 32'h0);
    nxt();
    redirect = 1'b0;
    mid();
    chk("s3_squash_valid", {31'h0, if_valid}, 32'h0);
    chk("s3_squash_instr", if_instr, 32'h0000_0013);
    chk("s3_drop_req", {31'h0, bus.imem_req}, 32'h0);
    nxt();
    mid();
    chk("s3_tgt_req", {31'h0, bus.imem_req}, 32'h1);
    chk("s3_tgt_addr", bus.imem_addr, 32'h3000);
    nxt();
    repeat (3) nxt();
    mid();
    chk("s3_tgt_pc", if_pc, 32'h3000);
    nxt();
    end_scn("s3");

    // Redirect coincident with rvalid and stall
    do_reset(1);
    push(32'h5000, 32'hA5A5_5000);
    push(32'h5004, 32'hA5A5_5004);
    nxt();
    nxt();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h5000;
    mid();
    chk("s4_req", {31'h0, bus.imem_req}, 32'h1);
    chk("s4_addr", bus.imem_addr, 32'h5000);
    nxt();
    stall    = 1'b0;
    redirect = 1'b0;
    mid();
    chk("s4_squash_valid", {31'h0, if_valid}, 32'h0);
    chk("s4_squash_instr", if_instr, 32'h0000_0013);
    nxt();
    nxt();
    nxt();
    end_scn("s4");

    // Double redirect in DROP, unaligned second target
    do_reset(3);
    push(32'h4000, 32'hA5A5_4000);
    nxt();
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    mid();
    chk("s5_req_c1", {31'h0, bus.imem_req}, 32'h0);
    nxt();
    redirect_pc = 32'h4002;
    mid();
    chk("s5_req_c2", {31'h0, bus.imem_req}, 32'h0);
    nxt();
    redirect = 1'b0;
    mid();
    chk("s5_req_c3", {31'h0, bus.imem_req}, 32'h1);
    chk("s5_addr_c3", bus.imem_addr, 32'h4000);
    nxt();
    repeat (3) nxt();
    mid();
    chk("s5_tgt_pc", if_pc, 32'h4000);
    nxt();
    end_scn("s5");

    // PC wrap, then asynchronous reset mid-BUSY and restart
    do_reset(1);
    push(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    push(32'h0000_0000, 32'hA5A5_0000);
    nxt();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    mid();
    chk("s6_req_top", {31'h0, bus.imem_req}, 32'h1);
    chk("s6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    nxt();
    redirect = 1'b0;
    mid();
    chk("s6_wrap_req", {31'h0, bus.imem_req}, 32'h1);
    chk("s6_wrap_addr", bus.imem_addr, 32'h0);
    nxt();
    nxt();
    mid();
    #1;
    chk("s6_leftover", exp_q.size(), 32'h0);
    chk("s6_busy_req", {31'h0, bus.imem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    do_reset(1);
    push(32'h2000, 32'h0050_0093);
    mid();
    chk("s6_restart_req", {31'h0, bus.imem_req}, 32'h1);
    chk("s6_restart_addr", bus.imem_addr, 32'h2000);
    nxt();
    nxt();
    nxt();
    end_scn("s6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
